// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
`timescale 1ns/1ps
package disp_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [1:0] eng_state_t;

  localparam eng_state_t ENG_IDLE   = 2'd0;
  localparam eng_state_t ENG_CONV_M = 2'd1;
  localparam eng_state_t ENG_CONV_H = 2'd2;
  localparam eng_state_t ENG_COMMIT = 2'd3;

  localparam digit_idx_t DIG_MIN_ONES = 2'd0;
  localparam digit_idx_t DIG_MIN_TENS = 2'd1;
  localparam digit_idx_t DIG_HR_ONES  = 2'd2;
  localparam digit_idx_t DIG_HR_TENS  = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 9 first, entry 0 last.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] pat;
    if (bcd <= 4'd9) pat = SEG_TABLE[bcd];
    else pat = SEG_BLANK;
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential subtract-10 converter: start loads value, done flags the final tens/ones.
`timescale 1ns/1ps
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       start,
  input  logic [5:0] value,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       done
);

  logic [5:0] rem_q, rem_d;
  logic [2:0] tens_q, tens_d;
  logic       active_q, active_d;

  // One subtraction per cycle while the remainder is still 10 or more.
  always_comb begin
    rem_d    = rem_q;
    tens_d   = tens_q;
    active_d = active_q;
    if (clr) begin
      rem_d    = 6'd0;
      tens_d   = 3'd0;
      active_d = 1'b0;
    end else if (start) begin
      rem_d    = value;
      tens_d   = 3'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (rem_q >= 6'd10) begin
        rem_d  = rem_q - 6'd10;
        tens_d = tens_q + 3'd1;
      end else begin
        active_d = 1'b0;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= 6'd0;
      tens_q   <= 3'd0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      tens_q   <= tens_d;
      active_q <= active_d;
    end
  end

  assign tens = tens_q;
  assign ones = rem_q[3:0];
  assign done = active_q && (rem_q < 6'd10);

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit common-anode scan controller with per-frame BCD conversion and blinking.
// Define DISP_LZB_EN to blank a leading zero in the hour-tens position.
`timescale 1ns/1ps
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] hours_in,
  input  logic [5:0] minutes_in,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       conv_busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]   presc_q, presc_d;
  digit_idx_t      idx_q, idx_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            phase_q, phase_d;
  eng_state_t      state_q, state_d;
  logic [5:0]      snap_h_q, snap_h_d;
  logic [2:0]      mt_q, mt_d, ht_q, ht_d;
  logic [3:0]      mo_q, mo_d, ho_q, ho_d;
  logic [3:0][3:0] dbuf_q, dbuf_d;
  logic [3:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic            busy_q, busy_d;

  logic       tc, frame_end;
  logic       bcd_start;
  logic [5:0] bcd_value;
  logic [2:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       bcd_done;
  logic [3:0] lit_val;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .clr   (~en),
    .start (bcd_start),
    .value (bcd_value),
    .tens  (bcd_tens),
    .ones  (bcd_ones),
    .done  (bcd_done)
  );

  // Prescaler, digit index, frame counter and blink phase.
  always_comb begin
    tc        = (presc_q == PRESC_LAST);
    frame_end = en && tc && (idx_q == DIG_HR_TENS);
    presc_d   = presc_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    phase_d   = phase_q;
    if (!en) begin
      presc_d = '0;
      idx_d   = DIG_MIN_ONES;
      frame_d = '0;
      phase_d = 1'b0;
    end else if (tc) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      if (frame_end) begin
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end else begin
        frame_d = frame_q;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Conversion engine; the single converter is reused for minutes then hours.
  always_comb begin
    state_d   = state_q;
    snap_h_d  = snap_h_q;
    mt_d      = mt_q;
    mo_d      = mo_q;
    ht_d      = ht_q;
    ho_d      = ho_q;
    dbuf_d    = dbuf_q;
    bcd_start = 1'b0;
    bcd_value = minutes_in;
    if (!en) begin
      state_d = ENG_IDLE;
    end else begin
      case (state_q)
        ENG_IDLE: begin
          if (frame_end) begin
            bcd_start = 1'b1;
            bcd_value = minutes_in;
            snap_h_d  = hours_in;
            state_d   = ENG_CONV_M;
          end else begin
            state_d = ENG_IDLE;
          end
        end
        ENG_CONV_M: begin
          if (bcd_done) begin
            mt_d      = bcd_tens;
            mo_d      = bcd_ones;
            bcd_start = 1'b1;
            bcd_value = snap_h_q;
            state_d   = ENG_CONV_H;
          end else begin
            state_d = ENG_CONV_M;
          end
        end
        ENG_CONV_H: begin
          if (bcd_done) begin
            ht_d    = bcd_tens;
            ho_d    = bcd_ones;
            state_d = ENG_COMMIT;
          end else begin
            state_d = ENG_CONV_H;
          end
        end
        ENG_COMMIT: begin
          dbuf_d  = {{1'b0, ht_q}, ho_q, {1'b0, mt_q}, mo_q};
          state_d = ENG_IDLE;
        end
        default: state_d = ENG_IDLE;
      endcase
    end
    busy_d = (state_d != ENG_IDLE);
  end

  // Next anode/segment pattern, computed from the upcoming digit index.
  always_comb begin
    lit_val = dbuf_q[idx_d];
    an_n_d  = 4'b1111;
    seg_n_d = SEG_BLANK;
    if (!en) begin
      an_n_d  = 4'b1111;
      seg_n_d = SEG_BLANK;
    end else if (phase_d && blink_mask[idx_d]) begin
      an_n_d  = 4'b1111;
      seg_n_d = SEG_BLANK;
    end else begin
      an_n_d = ~(4'b0001 << idx_d);
`ifdef DISP_LZB_EN
      if ((idx_d == DIG_HR_TENS) && (lit_val == 4'd0)) seg_n_d = SEG_BLANK;
      else seg_n_d = seg_encode(lit_val);
`else
      seg_n_d = seg_encode(lit_val);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= DIG_MIN_ONES;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      state_q  <= ENG_IDLE;
      snap_h_q <= 6'd0;
      mt_q     <= 3'd0;
      mo_q     <= 4'd0;
      ht_q     <= 3'd0;
      ho_q     <= 4'd0;
      dbuf_q   <= '0;
      an_n_q   <= 4'b1111;
      seg_n_q  <= SEG_BLANK;
      busy_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      state_q  <= state_d;
      snap_h_q <= snap_h_d;
      mt_q     <= mt_d;
      mo_q     <= mo_d;
      ht_q     <= ht_d;
      ho_q     <= ho_d;
      dbuf_q   <= dbuf_d;
      an_n_q   <= an_n_d;
      seg_n_q  <= seg_n_d;
      busy_q   <= busy_d;
    end
  end

  assign an_n      = an_n_q;
  assign seg_n     = seg_n_q;
  assign conv_busy = busy_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl with SCAN_DIV=4 and BLINK_FRAMES=2.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] hours_in;
  logic [5:0] minutes_in;
  logic [3:0] blink_mask;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       conv_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_f  = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_exp_t;

  slot_exp_t sb_q[$];

  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hours_in   (hours_in),
    .minutes_in (minutes_in),
    .blink_mask (blink_mask),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .conv_busy  (conv_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic void push_frame(input int h, input int m, input logic [3:0] mask, input bit phase);
    int        dig[4];
    slot_exp_t e;
    dig[0] = m % 10;
    dig[1] = m / 10;
    dig[2] = h % 10;
    dig[3] = h / 10;
    for (int i = 0; i < 4; i++) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      if (!(phase && mask[i])) begin
        e.an[i] = 1'b0;
        e.seg   = seg_ref(dig[i]);
`ifdef DISP_LZB_EN
        if (i == 3 && dig[3] == 0) e.seg = 7'h7F;
`endif
      end
      sb_q.push_back(e);
    end
  endfunction

  task automatic sample_slot(input string tag);
    slot_exp_t e;
    check_val({tag, "_sb_avail"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_an"}, 32'(an_n), 32'(e.an));
      check_val({tag, "_seg"}, 32'(seg_n), 32'(e.seg));
    end
  endtask

  // Scan starts one edge after en/rst release; sample mid-slot of frame 0.
  task automatic check_frame0(input string tag);
    for (int i = 0; i < 4; i++) begin
      repeat ((i == 0) ? 2 : 4) @(negedge clk);
      sample_slot($sformatf("%s_d%0d", tag, i));
    end
  endtask

  task automatic wait_rise(input string tag);
    int k = 0;
    @(negedge clk);
    while (!conv_busy && k < 64) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_conv_start"}, 32'(conv_busy), 32'd1);
  endtask

  task automatic run_scn(input string tag, input int h, input int m, input logic [3:0] mask,
                         input int mid_m, input bit use_mid);
    int busy;
    int t;
    hours_in   = 6'(h);
    minutes_in = 6'(m);
    blink_mask = mask;
    push_frame(h, m, mask, bit'(((frame_f + 1) / 2) % 2));
    wait_rise(tag);
    if (use_mid) minutes_in = 6'(mid_m);
    busy = 1;
    while (busy < 40) begin
      @(negedge clk);
      if (!conv_busy) break;
      busy++;
    end
    check_val({tag, "_busy_cycles"}, 32'(busy), 32'((m / 10 + 1) + (h / 10 + 1) + 1));
    t = busy;
    for (int i = 0; i < 4; i++) begin
      if (18 + 4 * i > t) repeat (18 + 4 * i - t) @(negedge clk);
      t = 18 + 4 * i;
      sample_slot($sformatf("%s_d%0d", tag, i));
    end
    frame_f += 2;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    hours_in   = 6'd0;
    minutes_in = 6'd0;
    blink_mask = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_an", 32'(an_n), 32'hF);
    check_val("rst_seg", 32'(seg_n), 32'h7F);
    check_val("rst_busy", 32'(conv_busy), 32'd0);

    hours_in   = 6'd23;
    minutes_in = 6'd59;
    push_frame(0, 0, 4'h0, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
    check_frame0("boot");
    frame_f = 1;

    run_scn("t2359", 23, 59, 4'b0000, 0, 1'b0);
    run_scn("t6363", 63, 63, 4'b0000, 0, 1'b0);
    run_scn("blink_on", 12, 34, 4'b1100, 0, 1'b0);
    run_scn("blink_off", 12, 34, 4'b1100, 0, 1'b0);
    run_scn("lzb", 7, 5, 4'b0000, 0, 1'b0);
    run_scn("mid_chg", 0, 30, 4'b0000, 31, 1'b1);
    run_scn("after_chg", 0, 31, 4'b0000, 0, 1'b0);

    // Drop en while converting 45:50; buffer must keep 00:31.
    hours_in   = 6'd45;
    minutes_in = 6'd50;
    wait_rise("en_drop");
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_val("en_off_an", 32'(an_n), 32'hF);
    check_val("en_off_seg", 32'(seg_n), 32'h7F);
    check_val("en_off_busy", 32'(conv_busy), 32'd0);
    repeat (4) @(negedge clk);
    check_val("en_off_hold_an", 32'(an_n), 32'hF);
    push_frame(0, 31, 4'h0, 1'b0);
    en = 1'b1;
    check_frame0("en_re");
    frame_f = 1;
    run_scn("post_en", 45, 50, 4'b0000, 0, 1'b0);

    // Reset while converting; buffer must clear with no commit.
    wait_rise("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_an", 32'(an_n), 32'hF);
    check_val("rst_mid_seg", 32'(seg_n), 32'h7F);
    check_val("rst_mid_busy", 32'(conv_busy), 32'd0);
    push_frame(0, 0, 4'h0, 1'b0);
    rst = 1'b0;
    check_frame0("rst_re");
    frame_f = 1;
    run_scn("post_rst", 45, 50, 4'b0000, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
